alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter that shares one `arithmetic` unit between clients such as the execute stage and a multi-cycle helper. It accepts tagged operation requests over valid/ready handshakes and grants them round-robin into a single issue register that drives the ALU. Each ALU result, or an error flag when the ALU reports an invalid operation, is returned in a per-requester response buffer. The block sits between the requesters and the `arithmetic` instance; the ALU is driven through this block's `alu_*` ports.

## Interface
- TAG_WIDTH, 4, width of the opaque request tag echoed back on the response

Ports (index i = 0,1 on all [1:0] arrays):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  [1:0]  request present
- req_ready  out  [1:0]  request accepted this cycle when valid & ready
- req_lhs, req_rhs  in  [1:0][31:0]  operands
- req_operation  in  [1:0][2:0]  funct3-style op select, ALU encoding
- req_metadata  in  [1:0][6:0]  funct7-style modifier, ALU encoding
- req_tag  in  [1:0][TAG_WIDTH-1:0]  opaque tag
- rsp_valid  out  [1:0]  response buffer full
- rsp_ready  in  [1:0]  requester consumes response
- rsp_result  out  [1:0][31:0]  ALU result; 0 on error
- rsp_error  out  [1:0]  ALU reported invalid operation
- rsp_tag  out  [1:0][TAG_WIDTH-1:0]  echoed tag
- alu_lhs, alu_rhs  out  32  to ALU
- alu_operation  out  3  to ALU
- alu_metadata  out  7  to ALU
- alu_result  in  32  from ALU, used combinationally in the cycle the issue register is valid
- alu_valid  in  1  from ALU, low means illegal operation/metadata combination

## Operation
- State:
  - issue register: valid bit, owner, operands, operation, metadata, tag.
  - two response buffers: one entry each.
  - round-robin pointer `prio`.
- Issue advance: `adv = iss_valid & (!rsp_valid[owner] | rsp_ready[owner])`.
- Issue capacity: `can_accept = !iss_valid | adv`.
- Grant, combinational:
  - If only one requester is valid, it wins.
  - If both are valid, `prio` wins.
  - `req_ready[i] = can_accept & grant[i]`.
  - req_ready never depends on rsp_ready of the other requester.
- On a handshake:
  - Load the issue register with the request and owner.
  - Set `prio` to the other requester.
  - `prio` is unchanged when no grant occurs.
- ALU drive:
  - While the issue register is valid, the `alu_*` outputs reflect its contents.
  - While it is empty, they drive 0 (lhs=rhs=0, operation=0, metadata=0).
- Capture on `adv`:
  - Response buffer [owner] loads `result = alu_valid ? alu_result : 0`, `error = !alu_valid`, and the tag.
  - Issue register clears unless it is reloaded the same edge.
- Response pop: `rsp_valid & rsp_ready` clears the buffer, unless it is refilled on the same edge (pop and load together leaves it full with new data).
- Head-of-line blocking: a stalled owner response holds the issue register. That blocks both requesters; this is intended.
- Ordering: responses per requester are returned in acceptance order.

## Timing
- Reset (rst=0, asynchronous):
  - iss_valid=0, rsp_valid=0, rsp_result=0, rsp_error=0, rsp_tag=0, prio=0.
  - alu_* = 0; req_ready=0 while in reset.
  - Any in-flight operation is dropped; no response appears for it after release.
- First grant is possible in the first cycle after rst deasserts.
- Latency: a request accepted at edge N is evaluated by the ALU in cycle N+1 and captured at edge N+1. rsp_valid is high from N+1 onward (2 edges from request presentation).
- Throughput: one operation per cycle sustained, alternating requesters, when rsp_ready is held high.
- Backpressure chain for requester r:
  - With rsp_ready[r]=0, the 1st op fills the response buffer and the 2nd occupies the issue register.
  - req_ready then drops to 0 for both requesters until rsp_ready[r] rises.
  - On the cycle rsp_ready[r] rises: response pop, issue advance and a new grant all occur on the same edge.
- Outputs hold stable while rsp_valid=1 and rsp_ready=0.

## Test plan
- Single add: req0 op=0, meta=0x00, lhs=0x0000_0001, rhs=0x0000_ffff, tag=5, rsp_ready high -> accepted the first cycle; rsp_valid[0]=1 one edge later, result=0x0001_0000, tag=5, error=0.
- Contention: both req_valid held for 4 cycles from reset, rsp_ready=11 -> grants 0,1,0,1; each requester receives 2 responses in order with matching tags.
- Backpressure: rsp_ready[0]=0, req0 issues 3 XORs (0x1111_ffff ^ 0x0204_f0f0 etc.) -> 2 accepted, then req_ready=00; req1 is also blocked. Raise rsp_ready[0] -> first response 0x1315_0f0f popped, third op accepted the same edge, no loss or reorder.
- Error: req1 op=0, meta=0x01 -> rsp_error[1]=1, rsp_result[1]=0; next request from req1 (SRA op=5, meta=0x20, 0xa863_201f >> 4) returns 0xfa86_3201.
- Reset mid-flight: fill issue and both response buffers, pulse rst low between edges -> all outputs 0 immediately; after release, no stale rsp_valid, and prio=0 (req0 wins the first tie).
- SLT/SLTU: req0 op=2 with 0xffff_ffff < 0 -> result 1; op=3 with the same operands -> result 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between two requesters and the ALU arbiter
interface alu_arbiter_if #(parameter int TAG_WIDTH = 4);
    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0][31:0]           req_lhs;
    logic [1:0][31:0]           req_rhs;
    logic [1:0][2:0]            req_operation;
    logic [1:0][6:0]            req_metadata;
    logic [1:0][TAG_WIDTH-1:0]  req_tag;
    logic [1:0]                 rsp_valid;
    logic [1:0]                 rsp_ready;
    logic [1:0][31:0]           rsp_result;
    logic [1:0]                 rsp_error;
    logic [1:0][TAG_WIDTH-1:0]  rsp_tag;

    modport master (
        output req_valid, req_lhs, req_rhs, req_operation, req_metadata, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_error, rsp_tag
    );

    modport slave (
        input  req_valid, req_lhs, req_rhs, req_operation, req_metadata, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_error, rsp_tag
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two tagged requesters
module alu_arbiter #(
    parameter int TAG_WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus,
    output logic [31:0]   alu_lhs,
    output logic [31:0]   alu_rhs,
    output logic [2:0]    alu_operation,
    output logic [6:0]    alu_metadata,
    input  logic [31:0]   alu_result,
    input  logic          alu_valid
);
    logic                       iss_valid_q, iss_valid_d;
    logic                       iss_owner_q, iss_owner_d;
    logic [31:0]                iss_lhs_q, iss_lhs_d;
    logic [31:0]                iss_rhs_q, iss_rhs_d;
    logic [2:0]                 iss_op_q, iss_op_d;
    logic [6:0]                 iss_meta_q, iss_meta_d;
    logic [TAG_WIDTH-1:0]       iss_tag_q, iss_tag_d;
    logic                       prio_q, prio_d;
    logic [1:0]                 rsp_valid_q, rsp_valid_d;
    logic [1:0][31:0]           rsp_result_q, rsp_result_d;
    logic [1:0]                 rsp_error_q, rsp_error_d;
    logic [1:0][TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;

    logic [1:0] grant;
    logic [1:0] req_ready;
    logic       adv;
    logic       can_accept;
    logic       win;

    // The issue slot only drains into its owner's buffer, so a stalled owner stalls everyone.
    always_comb begin
        grant = bus.req_valid;
        if (bus.req_valid == 2'b11) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end
        adv        = iss_valid_q && (!rsp_valid_q[iss_owner_q] || bus.rsp_ready[iss_owner_q]);
        can_accept = !iss_valid_q || adv;
        req_ready  = (rst && can_accept) ? grant : 2'b00;
        win        = req_ready[1];
    end

    always_comb begin
        iss_valid_d  = iss_valid_q;
        iss_owner_d  = iss_owner_q;
        iss_lhs_d    = iss_lhs_q;
        iss_rhs_d    = iss_rhs_q;
        iss_op_d     = iss_op_q;
        iss_meta_d   = iss_meta_q;
        iss_tag_d    = iss_tag_q;
        prio_d       = prio_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        rsp_tag_d    = rsp_tag_q;

        for (int i = 0; i < 2; i++) begin
            if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end

        // Capture after the pop so a pop and refill on one edge leaves the buffer full.
        if (adv) begin
            rsp_valid_d[iss_owner_q]  = 1'b1;
            rsp_result_d[iss_owner_q] = alu_valid ? alu_result : 32'h0;
            rsp_error_d[iss_owner_q]  = !alu_valid;
            rsp_tag_d[iss_owner_q]    = iss_tag_q;
            iss_valid_d               = 1'b0;
        end

        if (req_ready != 2'b00) begin
            iss_valid_d = 1'b1;
            iss_owner_d = win;
            iss_lhs_d   = bus.req_lhs[win];
            iss_rhs_d   = bus.req_rhs[win];
            iss_op_d    = bus.req_operation[win];
            iss_meta_d  = bus.req_metadata[win];
            iss_tag_d   = bus.req_tag[win];
            prio_d      = !win;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_valid_q  <= 1'b0;
            iss_owner_q  <= 1'b0;
            iss_lhs_q    <= '0;
            iss_rhs_q    <= '0;
            iss_op_q     <= '0;
            iss_meta_q   <= '0;
            iss_tag_q    <= '0;
            prio_q       <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= '0;
            rsp_tag_q    <= '0;
        end else begin
            iss_valid_q  <= iss_valid_d;
            iss_owner_q  <= iss_owner_d;
            iss_lhs_q    <= iss_lhs_d;
            iss_rhs_q    <= iss_rhs_d;
            iss_op_q     <= iss_op_d;
            iss_meta_q   <= iss_meta_d;
            iss_tag_q    <= iss_tag_d;
            prio_q       <= prio_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_error  = rsp_error_q;
    assign bus.rsp_tag    = rsp_tag_q;

    assign alu_lhs       = iss_valid_q ? iss_lhs_q  : 32'h0;
    assign alu_rhs       = iss_valid_q ? iss_rhs_q  : 32'h0;
    assign alu_operation = iss_valid_q ? iss_op_q   : 3'h0;
    assign alu_metadata  = iss_valid_q ? iss_meta_q : 7'h0;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed bench for alu_arbiter against a behavioural model
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.TAG_WIDTH(4)) bus ();

    logic [31:0] alu_lhs, alu_rhs, alu_result;
    logic [2:0]  alu_operation;
    logic [6:0]  alu_metadata;
    logic        alu_valid;

    alu_arbiter #(.TAG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_operation(alu_operation),
        .alu_metadata(alu_metadata), .alu_result(alu_result), .alu_valid(alu_valid)
    );

    int total = 0;
    int bad   = 0;

    // Environment ALU: {ok, result}; the result is deliberately left as garbage when not ok.
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic [6:0] m);
        logic        ok;
        logic [31:0] r;
        ok = (m == 7'h00);
        r  = a + b;
        case (op)
            3'd0: begin ok = (m == 7'h00) || (m == 7'h20); r = (m == 7'h20) ? a - b : a + b; end
            3'd1: r = a << b[4:0];
            3'd2: r = {31'b0, $signed(a) < $signed(b)};
            3'd3: r = {31'b0, a < b};
            3'd4: r = a ^ b;
            3'd5: begin
                ok = (m == 7'h00) || (m == 7'h20);
                r  = (m == 7'h20) ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return {ok, r};
    endfunction

    assign {alu_valid, alu_result} = alu_ref(alu_lhs, alu_rhs, alu_operation, alu_metadata);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: at most one accepted-but-uncaptured op, plus one held response per requester.
    logic        pv, po, prio_m;
    logic [31:0] pl, pr;
    logic [2:0]  pop;
    logic [6:0]  pm;
    logic [3:0]  pt;
    logic [1:0]  bv;
    logic [31:0] br [2];
    logic        be [2];
    logic [3:0]  bt [2];

    always @(negedge clk) begin
        logic [1:0]  eg, er;
        logic        adv, can;
        logic [32:0] a;
        int          w;
        if (!rst) begin
            pv = 1'b0; bv = 2'b00; prio_m = 1'b0;
            chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            chk("rst_alu_lhs", alu_lhs, 32'h0);
        end else begin
            eg = bus.req_valid;
            if (eg == 2'b11) eg = prio_m ? 2'b10 : 2'b01;
            adv = pv && (!bv[po] || bus.rsp_ready[po]);
            can = !pv || adv;
            er  = can ? eg : 2'b00;
            chk("req_ready", 32'(bus.req_ready), 32'(er));
            for (int i = 0; i < 2; i++) begin
                chk("rsp_valid", 32'(bus.rsp_valid[i]), 32'(bv[i]));
                if (bv[i]) begin
                    chk("rsp_result", bus.rsp_result[i], br[i]);
                    chk("rsp_error", 32'(bus.rsp_error[i]), 32'(be[i]));
                    chk("rsp_tag", 32'(bus.rsp_tag[i]), 32'(bt[i]));
                end
            end
            chk("alu_lhs", alu_lhs, pv ? pl : 32'h0);
            chk("alu_rhs", alu_rhs, pv ? pr : 32'h0);
            chk("alu_op", 32'(alu_operation), pv ? 32'(pop) : 32'h0);
            chk("alu_meta", 32'(alu_metadata), pv ? 32'(pm) : 32'h0);
            for (int i = 0; i < 2; i++) begin
                if (bv[i] && bus.rsp_ready[i]) bv[i] = 1'b0;
            end
            if (adv) begin
                a      = alu_ref(pl, pr, pop, pm);
                bv[po] = 1'b1;
                br[po] = a[32] ? a[31:0] : 32'h0;
                be[po] = !a[32];
                bt[po] = pt;
                pv     = 1'b0;
            end
            if (er != 2'b00) begin
                w  = int'(er[1]);
                pv = 1'b1; po = er[1];
                pl = bus.req_lhs[w]; pr = bus.req_rhs[w];
                pop = bus.req_operation[w]; pm = bus.req_metadata[w]; pt = bus.req_tag[w];
                prio_m = !er[1];
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [6:0] m, input logic [3:0] t);
        bus.req_valid[i]     = v;
        bus.req_lhs[i]       = a;
        bus.req_rhs[i]       = b;
        bus.req_operation[i] = op;
        bus.req_metadata[i]  = m;
        bus.req_tag[i]       = t;
    endtask

    // Called at posedge+1 with the pipeline idle; returns at posedge+1 after the response pops.
    task automatic single(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [6:0] m, input logic [3:0] t, input logic [31:0] exp_r,
                          input logic exp_e, input string nm);
        bus.rsp_ready = 2'b11;
        set_req(i, 1'b1, a, b, op, m, t);
        @(negedge clk);
        chk({nm, "_ready"}, 32'(bus.req_ready), (i == 1) ? 32'h2 : 32'h1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_valid"}, 32'(bus.rsp_valid[i]), 32'h1);
        chk({nm, "_result"}, bus.rsp_result[i], exp_r);
        chk({nm, "_error"}, 32'(bus.rsp_error[i]), 32'(exp_e));
        chk({nm, "_tag"}, 32'(bus.rsp_tag[i]), 32'(t));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [32:0] pin;
        rst = 1'b0;
        bus.req_valid = 2'b00; bus.rsp_ready = 2'b11;
        bus.req_lhs = '0; bus.req_rhs = '0; bus.req_operation = '0; bus.req_metadata = '0; bus.req_tag = '0;

        pin = alu_ref(32'h1111_ffff, 32'h0204_f0f0, 3'd4, 7'h00);
        chk("pin_xor", pin[31:0], 32'h1315_0f0f);
        pin = alu_ref(32'ha863_201f, 32'd4, 3'd5, 7'h20);
        chk("pin_sra", pin[31:0], 32'hfa86_3201);
        pin = alu_ref(32'h1, 32'h1, 3'd0, 7'h01);
        chk("pin_err", 32'(pin[32]), 32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_result0", bus.rsp_result[0], 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Contention straight out of reset: req0 must win first.
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 32'(k), 32'd10, 3'd0, 7'h00, 4'(k));
            set_req(1, 1'b1, 32'(k), 32'd20, 3'd0, 7'h00, 4'(8 + k));
            @(negedge clk);
            chk("contention_grant", 32'(bus.req_ready), (k % 2 == 1) ? 32'h2 : 32'h1);
            @(posedge clk); #1;
        end
        bus.req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        single(0, 32'h0000_0001, 32'h0000_ffff, 3'd0, 7'h00, 4'd5, 32'h0001_0000, 1'b0, "add");
        single(1, 32'h0000_0001, 32'h0000_0002, 3'd0, 7'h01, 4'd3, 32'h0, 1'b1, "err");
        single(1, 32'ha863_201f, 32'd4, 3'd5, 7'h20, 4'd4, 32'hfa86_3201, 1'b0, "sra");
        single(0, 32'hffff_ffff, 32'h0, 3'd2, 7'h00, 4'd6, 32'h1, 1'b0, "slt");
        single(0, 32'hffff_ffff, 32'h0, 3'd3, 7'h00, 4'd7, 32'h0, 1'b0, "sltu");

        // Backpressure on requester 0.
        bus.rsp_ready = 2'b10;
        set_req(0, 1'b1, 32'h1111_ffff, 32'h0204_f0f0, 3'd4, 7'h00, 4'd1);
        @(negedge clk); chk("bp_first", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'h2222_0000, 32'h0000_3333, 3'd4, 7'h00, 4'd2);
        @(negedge clk); chk("bp_second", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'h4444_4444, 32'h0404_0404, 3'd4, 7'h00, 4'd3);
        set_req(1, 1'b1, 32'h1, 32'h1, 3'd0, 7'h00, 4'd9);
        @(negedge clk); chk("bp_blocked", 32'(bus.req_ready), 32'h0);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        bus.rsp_ready = 2'b11;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.req_ready), 32'h1);
        chk("bp_release_result", bus.rsp_result[0], 32'h1315_0f0f);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        // Fill issue register and both response buffers, then reset between edges.
        bus.rsp_ready = 2'b00;
        set_req(0, 1'b1, 32'h5, 32'h6, 3'd6, 7'h00, 4'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        set_req(1, 1'b1, 32'h7, 32'h8, 3'd7, 7'h00, 4'd2);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        set_req(0, 1'b1, 32'h9, 32'ha, 3'd0, 7'h00, 4'd3);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("full_rsp_valid", 32'(bus.rsp_valid), 32'h3);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("midrst_rsp_result1", bus.rsp_result[1], 32'h0);
        chk("midrst_alu_lhs", alu_lhs, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.rsp_ready = 2'b11;
        set_req(0, 1'b1, 32'h1, 32'h2, 3'd0, 7'h00, 4'd4);
        set_req(1, 1'b1, 32'h3, 32'h4, 3'd0, 7'h00, 4'd5);
        @(negedge clk);
        chk("postrst_tie", 32'(bus.req_ready), 32'h1);
        chk("postrst_stale", 32'(bus.rsp_valid), 32'h0);
        @(posedge clk); #1;

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                int          sel;
                logic [6:0]  m;
                sel = int'($urandom_range(0, 7));
                m   = (sel < 5) ? 7'h00 : (sel < 7) ? 7'h20 : 7'($urandom);
                set_req(i, ($urandom_range(0, 3) != 0), $urandom, $urandom,
                        3'($urandom_range(0, 7)), m, 4'($urandom));
                bus.rsp_ready[i] = ($urandom_range(0, 2) != 0);
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        repeat (5) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
